// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default sizes and the
// address-width helper used by the register file and its scoreboard.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // Address width for n registers; never below one bit.
   function automatic int aw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports: clk, rst (async high); wen/wa write clears a busy bit;
// rsv_en/rsv_a reserve sets one; busy vector, rsv_ok, busy_cnt out.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = aw_of(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    wa,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_a,
   output logic [NREGS-1:0] busy,
   output logic             rsv_ok,
   output logic [AW:0]      busy_cnt
);

   logic set;
   logic clr;
   logic same;
   logic inc;
   logic dec;

   // A write landing on the reserved register frees it this cycle,
   // so the new reservation can be taken over it.
   assign rsv_ok = !busy[rsv_a] || (wen && (wa == rsv_a));

   assign set  = rsv_en && rsv_ok && (rsv_a != '0);
   assign clr  = wen && (wa != '0);
   assign same = set && clr && (wa == rsv_a);

   // Count tracks popcount: a reserve over a write to the same
   // register leaves the bit set, so neither side moves the count.
   assign inc = set && !busy[rsv_a];
   assign dec = clr && busy[wa] && !same;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (clr) busy[wa] <= 1'b0;
         // Later assignment wins: reservation beats the write clear.
         if (set) busy[rsv_a] <= 1'b1;
         if (inc && !dec)
            busy_cnt <= busy_cnt + (AW+1)'(1);
         else if (dec && !inc)
            busy_cnt <= busy_cnt - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hard-wired to zero and a busy
// scoreboard. Ports: clk, rst (async high); ra/rd/rbusy packed read
// ports; wen/wa/wd write port; rsv_en/rsv_a/rsv_ok reserve; busy_cnt.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREGS  = NREGS_DEF,
   parameter  int NREAD  = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = aw_of(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   ra,
   output logic [NREAD*XLEN-1:0] rd,
   output logic [NREAD-1:0]      rbusy,
   input  logic                  wen,
   input  logic [AW-1:0]         wa,
   input  logic [XLEN-1:0]       wd,
   input  logic                  rsv_en,
   input  logic [AW-1:0]         rsv_a,
   output logic                  rsv_ok,
   output logic [AW:0]           busy_cnt
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr;

   assign wr = wen && (wa != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREGS; k++)
            regs[k] <= '0;
      end else if (wr) begin
         regs[wa] <= wd;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .wa       (wa),
      .rsv_en   (rsv_en),
      .rsv_a    (rsv_a),
      .busy     (busy),
      .rsv_ok   (rsv_ok),
      .busy_cnt (busy_cnt)
   );

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;

      assign a = ra[i*AW +: AW];

      // Forwarding is suppressed in reset so reads stay zero.
      assign hit = (BYPASS != 0) && !rst && wr && (wa == a);

      assign rd[i*XLEN +: XLEN] =
         hit         ? wd :
         (a == '0)   ? '0 :
         regs[a];

      assign rbusy[i] = hit ? 1'b0 : busy[a];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing and a
// non-bypassing instance share stimulus and a behavioural model.
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NREAD = 2;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wen = 1'b0;
   logic [AW-1:0] wa = '0;
   logic [XLEN-1:0] wd = '0;
   logic rsv_en = 1'b0;
   logic [AW-1:0] rsv_a = '0;
   logic [AW-1:0] ra0 = '0;
   logic [AW-1:0] ra1 = '0;
   logic [NREAD*AW-1:0] ra;

   logic [NREAD*XLEN-1:0] rd_b, rd_n;
   logic [NREAD-1:0] rbusy_b, rbusy_n;
   logic rsv_ok_b, rsv_ok_n;
   logic [AW:0] cnt_b, cnt_n;

   int total = 0;
   int passed = 0;

   // Model state
   logic [XLEN-1:0] m_reg [NREGS];
   bit m_busy [NREGS];

   assign ra = {ra1, ra0};

   always #5 clk = ~clk;

   regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
      .wen(wen), .wa(wa), .wd(wd), .rsv_en(rsv_en),
      .rsv_a(rsv_a), .rsv_ok(rsv_ok_b), .busy_cnt(cnt_b)
   );

   regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)
   ) dut_nb (
      .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
      .wen(wen), .wa(wa), .wd(wd), .rsv_en(rsv_en),
      .rsv_a(rsv_a), .rsv_ok(rsv_ok_n), .busy_cnt(cnt_n)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic bit exp_ok();
      if (rsv_a == 0) return 1'b1;
      return !m_busy[rsv_a] || (wen && wa == rsv_a);
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int k = 0; k < NREGS; k++) n += int'(m_busy[k]);
      return n;
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(
      input logic [AW-1:0] a, input bit byp);
      if (rst || a == 0) return '0;
      if (byp && wen && wa == a) return wd;
      return m_reg[a];
   endfunction

   function automatic bit exp_rbusy(
      input logic [AW-1:0] a, input bit byp);
      if (rst || a == 0) return 1'b0;
      if (byp && wen && wa == a) return 1'b0;
      return m_busy[a];
   endfunction

   // Model: register contents and pending flags as plain arrays.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREGS; k++) begin
            m_reg[k] = '0;
            m_busy[k] = 1'b0;
         end
      end else begin
         bit ok;
         ok = exp_ok();
         if (wen && wa != 0) begin
            m_reg[wa] = wd;
            m_busy[wa] = 1'b0;
         end
         if (rsv_en && ok && rsv_a != 0) m_busy[rsv_a] = 1'b1;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [AW-1:0] a;
      for (int i = 0; i < NREAD; i++) begin
         a = ra[i*AW +: AW];
         chk($sformatf("rd%0d_byp", i), 64'(rd_b[i*XLEN +: XLEN]),
             64'(exp_rd(a, 1'b1)));
         chk($sformatf("rd%0d_nobyp", i), 64'(rd_n[i*XLEN +: XLEN]),
             64'(exp_rd(a, 1'b0)));
         chk($sformatf("rbusy%0d_byp", i), 64'(rbusy_b[i]),
             64'(exp_rbusy(a, 1'b1)));
         chk($sformatf("rbusy%0d_nobyp", i), 64'(rbusy_n[i]),
             64'(exp_rbusy(a, 1'b0)));
      end
      chk("rsv_ok_byp", 64'(rsv_ok_b), 64'(exp_ok()));
      chk("rsv_ok_nobyp", 64'(rsv_ok_n), 64'(exp_ok()));
      chk("busy_cnt_byp", 64'(cnt_b), 64'(exp_cnt()));
      chk("busy_cnt_nobyp", 64'(cnt_n), 64'(exp_cnt()));
   end

   task automatic drive(input logic w, input logic [AW-1:0] a,
                        input logic [XLEN-1:0] d, input logic r,
                        input logic [AW-1:0] ra_, input logic [AW-1:0] p0);
      @(posedge clk);
      #1;
      wen = w; wa = a; wd = d;
      rsv_en = r; rsv_a = ra_;
      ra0 = p0;
   endtask

   task automatic idle(input logic [AW-1:0] p0);
      drive(1'b0, '0, '0, 1'b0, '0, p0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      wen = 1'b0; rsv_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      ra1 = 5'd3;
      #1;
      chk("reset_cnt_init", 64'(cnt_b), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Write/read with and without forwarding.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5);
      @(negedge clk);
      chk("wr_same_cycle_byp", 64'(rd_b[31:0]), 64'hDEADBEEF);
      chk("wr_same_cycle_nobyp", 64'(rd_n[31:0]), 64'h0);
      idle(5'd5);
      @(negedge clk);
      chk("wr_after_edge_byp", 64'(rd_b[31:0]), 64'hDEADBEEF);
      chk("wr_after_edge_nobyp", 64'(rd_n[31:0]), 64'hDEADBEEF);

      // Register zero ignores writes and reserves.
      drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, 5'd0);
      drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
      @(negedge clk);
      chk("x0_rsv_ok", 64'(rsv_ok_b), 64'd1);
      chk("x0_rd", 64'(rd_b[31:0]), 64'd0);
      chk("x0_rbusy", 64'(rbusy_b[0]), 64'd0);
      idle(5'd0);
      @(negedge clk);
      chk("x0_cnt", 64'(cnt_b), 64'd0);

      // Scoreboard reserve / WAW stall / release.
      drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
      @(negedge clk);
      chk("r7_first_ok", 64'(rsv_ok_b), 64'd1);
      drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
      @(negedge clk);
      chk("r7_rbusy", 64'(rbusy_b[0]), 64'd1);
      chk("r7_cnt", 64'(cnt_b), 64'd1);
      chk("r7_again_rejected", 64'(rsv_ok_b), 64'd0);
      drive(1'b1, 5'd7, 32'h77, 1'b0, '0, 5'd7);
      @(negedge clk);
      chk("w7_rbusy_byp", 64'(rbusy_b[0]), 64'd0);
      chk("w7_rbusy_nobyp", 64'(rbusy_n[0]), 64'd1);
      idle(5'd7);
      @(negedge clk);
      chk("w7_cnt", 64'(cnt_b), 64'd0);
      chk("w7_rbusy_after", 64'(rbusy_n[0]), 64'd0);

      // Same-register write and reserve in one cycle.
      drive(1'b0, '0, '0, 1'b1, 5'd9, 5'd9);
      drive(1'b1, 5'd9, 32'hAAAA5555, 1'b1, 5'd9, 5'd9);
      @(negedge clk);
      chk("same9_rsv_ok", 64'(rsv_ok_b), 64'd1);
      chk("same9_cnt_before", 64'(cnt_b), 64'd1);
      idle(5'd9);
      @(negedge clk);
      chk("same9_rd", 64'(rd_b[31:0]), 64'hAAAA5555);
      chk("same9_rbusy", 64'(rbusy_b[0]), 64'd1);
      chk("same9_cnt", 64'(cnt_b), 64'd1);

      // Asynchronous reset with data and a busy bit present.
      #2 rst = 1'b1;
      #1;
      chk("async_rst_rd", 64'(rd_b[31:0]), 64'd0);
      chk("async_rst_rbusy", 64'(rbusy_b[0]), 64'd0);
      chk("async_rst_cnt", 64'(cnt_b), 64'd0);
      drive(1'b1, 5'd3, 32'h5A5A, 1'b1, 5'd3, 5'd3);
      @(negedge clk);
      chk("rst_wen_rd_byp", 64'(rd_b[31:0]), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      wen = 1'b0; rsv_en = 1'b0;
      @(negedge clk);
      chk("rst_write_discarded", 64'(rd_b[31:0]), 64'd0);
      chk("rst_rsv_discarded", 64'(cnt_b), 64'd0);

      // Saturation.
      for (int r = 1; r < NREGS; r++)
         drive(1'b0, '0, '0, 1'b1, AW'(r), 5'd1);
      idle(5'd1);
      @(negedge clk);
      chk("sat_cnt", 64'(cnt_b), 64'(NREGS - 1));
      drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
      @(negedge clk);
      chk("sat_rsv_rejected", 64'(rsv_ok_b), 64'd0);
      idle(5'd5);
      @(negedge clk);
      chk("sat_cnt_hold", 64'(cnt_b), 64'(NREGS - 1));

      // Random stress; the compare process checks every cycle.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         @(posedge clk);
         #1;
         wen = ($urandom_range(0, 99) < 40);
         wa = AW'($urandom_range(0, NREGS - 1));
         wd = $urandom();
         rsv_en = ($urandom_range(0, 99) < 60);
         rsv_a = AW'($urandom_range(0, NREGS - 1));
         ra0 = AW'($urandom_range(0, NREGS - 1));
         ra1 = ($urandom_range(0, 3) == 0) ? wa :
               AW'($urandom_range(0, NREGS - 1));
      end
      idle(5'd0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two >= 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports, range 1..4.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding in the same cycle.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port ra  input  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port rd  output  NREAD*XLEN  packed read data; port i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have port rbusy  output  NREAD  busy flag of the register addressed on each read port.
REQ-010 SHALL have port wen  input  1  write enable.
REQ-011 SHALL have port wa  input  AW  write address.
REQ-012 SHALL have port wd  input  XLEN  write data.
REQ-013 SHALL have port rsv_en  input  1  reserve request; marks a register pending.
REQ-014 SHALL have port rsv_a  input  AW  register to reserve.
REQ-015 SHALL have port rsv_ok  output  1  combinational: reserve accepted this cycle.
REQ-016 SHALL have port busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-017 SHALL hard-wire register 0 to zero: reads return 0, rbusy 0; writes and reserves to 0 are ignored, with rsv_ok=1.
REQ-018 SHALL read combinationally (zero latency): rd[i] = reg[ra[i]].
REQ-019 SHALL, with BYPASS=1, return wd on rd[i] and clear rbusy[i] when wen=1, wa=ra[i] and wa!=0 in the same cycle.
REQ-020 SHALL, with BYPASS=0, return the old value and the old busy flag until the edge after the write.
REQ-021 SHALL update reg[wa] <= wd on the rising edge when wen=1 and wa!=0.
REQ-022 SHALL clear busy[wa] on the edge when wen=1 and wa!=0.
REQ-023 SHALL set busy[rsv_a] on the edge when rsv_en=1, rsv_ok=1 and rsv_a!=0.
REQ-024 SHALL assert rsv_ok = !busy[rsv_a] || (wen && wa==rsv_a); a reserve on a busy register is rejected (WAW stall) with no state change.
REQ-025 SHALL, when reserve and write target the same nonzero register in one cycle, leave busy=1 (the reservation wins) and store wd.
REQ-026 SHALL maintain busy_cnt as a registered counter: +1 per accepted nonzero reserve that sets a clear bit, -1 per write clearing a set bit, net 0 when both hit the same register; it SHALL always equal popcount(busy).
REQ-027 SHALL treat a write to a non-busy register as legal: data is stored and busy stays 0.
REQ-028 SHALL never let busy_cnt wrap; the maximum is NREGS-1.

Reset
REQ-029 SHALL, while rst=1, asynchronously force all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-030 SHALL make rd = 0 and rbusy = 0 for every address while rst=1; rsv_ok follows REQ-024 on the cleared state.
REQ-031 SHALL ignore wen and rsv_en on any edge where rst=1; reset mid-write discards the write.

Structure
REQ-032 SHALL place the XLEN and NREGS defaults and the AW derivation helper in the shared package regfile_pkg.
REQ-033 SHALL be implemented as one module plus one sub-module, rf_scoreboard, holding the busy bits, busy_cnt and the rsv_ok logic.
REQ-034 SHALL generate read ports with a generate loop; no hand-instantiated ports.

Verification
REQ-035 SHALL test reset: assert rst with registers holding data -> all rd=0, rbusy=0, busy_cnt=0 immediately, without a clock edge.
REQ-036 SHALL test write/read: wen=1, wa=5, wd=0xDEADBEEF, ra0=5 -> rd0=0xDEADBEEF in the same cycle (BYPASS=1) and after the edge; with BYPASS=0 it appears only after the edge.
REQ-037 SHALL test x0: write 0x1234 to reg 0, then reserve reg 0 -> rd=0, rbusy=0, rsv_ok=1, busy_cnt=0.
REQ-038 SHALL test scoreboard: reserve 7 -> rbusy=1, busy_cnt=1; reserve 7 again -> rsv_ok=0; write 7 -> busy clear, busy_cnt=0.
REQ-039 SHALL test simultaneous same-register events: busy[9]=1, wen to 9 and rsv_en to 9 in one cycle -> rsv_ok=1, reg9=wd, busy[9]=1, busy_cnt unchanged.
REQ-040 SHALL test saturation: reserve registers 1..NREGS-1 -> busy_cnt=NREGS-1, every further reserve rejected; a random stress run checks busy_cnt == popcount(busy) every cycle.
